// File: rtl/aes_pkg.sv
// Shared types and default sizing for the AES request scheduler.
package aes_pkg;
  localparam int AES_DW          = 128;
  localparam int AES_KW          = 128;
  localparam int AES_TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {IDLE, LOAD, BUSY, DONE, GAP} state_e;
endpackage

// File: rtl/aes_req_sched_if.sv
// Bundle of requester, response and AES core signals around the scheduler.
interface aes_req_sched_if
  import aes_pkg::*;
#(
  parameter int DW = AES_DW,
  parameter int KW = AES_KW
);
  logic          req0_valid;
  logic          req0_ready;
  logic [DW-1:0] req0_data;
  logic [KW-1:0] req0_key;
  logic          req1_valid;
  logic          req1_ready;
  logic [DW-1:0] req1_data;
  logic [KW-1:0] req1_key;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          core_en;
  logic [DW-1:0] core_data_in;
  logic [KW-1:0] core_key_in;
  logic [DW-1:0] core_data_out;
  logic          core_data_out_valid;
  logic          busy;

  // Scheduler side.
  modport slave (
    input  req0_valid, req0_data, req0_key, req1_valid, req1_data, req1_key,
    input  rsp_ready, core_data_out, core_data_out_valid,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
    output core_en, core_data_in, core_key_in, busy
  );

  // Requesters, response consumer and core together.
  modport master (
    output req0_valid, req0_data, req0_key, req1_valid, req1_data, req1_key,
    output rsp_ready, core_data_out, core_data_out_valid,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
    input  core_en, core_data_in, core_key_in, busy
  );
endinterface

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie.
module aes_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] valid_i,
  input  logic       en_i,
  input  logic       update_i,
  output logic [1:0] grant_o
);
  logic rr_q;

  always_comb begin
    grant_o = 2'b00;
    if (en_i) begin
      case (valid_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = rr_q ? 2'b10 : 2'b01;
        default: grant_o = 2'b00;
      endcase
    end
  end

  // After a grant the other requester gets priority on the next tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= 1'b0;
    end else if (update_i) begin
      rr_q <= grant_o[0];
    end
  end
endmodule

// File: rtl/aes_req_sched.sv
// Round-robin job scheduler for a single AES core: holds operands and enable
// for the whole encryption, returns a tagged result, aborts a hung core.
module aes_req_sched
  import aes_pkg::*;
#(
  parameter int DW          = AES_DW,
  parameter int KW          = AES_KW,
  parameter int TIMEOUT_CYC = AES_TIMEOUT_DEF,
  parameter int CNT_W       = 7
) (
  input logic            AES_clk,
  input logic            AES_rst_n,
  aes_req_sched_if.slave bus
);
  state_e         state_q;
  logic [CNT_W-1:0] cnt_q;
  logic           core_en_q;
  logic [DW-1:0]  core_data_in_q;
  logic [KW-1:0]  core_key_in_q;
  logic           job_id_q;
  logic           rsp_valid_q;
  logic           rsp_id_q;
  logic [DW-1:0]  rsp_data_q;
  logic           rsp_err_q;

  logic [1:0]     req_valid;
  logic [1:0]     grant;
  logic [1:0]     req_ready;
  logic           in_idle;
  logic           hs;
  logic [DW-1:0]  sel_data;
  logic [KW-1:0]  sel_key;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign in_idle   = (state_q == IDLE);

  aes_rr_arb2 u_arb (
    .clk_i    (AES_clk),
    .rst_ni   (AES_rst_n),
    .valid_i  (req_valid),
    .en_i     (in_idle),
    .update_i (hs),
    .grant_o  (grant)
  );

  // Ready is masked by reset so nothing is offered while the block is held.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign req_ready[gi] = grant[gi] & AES_rst_n;
  end

  assign hs       = |(req_valid & req_ready);
  assign sel_data = grant[1] ? bus.req1_data : bus.req0_data;
  assign sel_key  = grant[1] ? bus.req1_key  : bus.req0_key;

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      core_en_q      <= 1'b0;
      core_data_in_q <= '0;
      core_key_in_q  <= '0;
      job_id_q       <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_data_q     <= '0;
      rsp_err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs) begin
            core_data_in_q <= sel_data;
            core_key_in_q  <= sel_key;
            job_id_q       <= grant[1];
            core_en_q      <= 1'b1;
            state_q        <= LOAD;
          end
        end
        LOAD: begin
          cnt_q   <= '0;
          state_q <= BUSY;
        end
        BUSY: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // A result in the final watchdog cycle still counts as success.
          if (bus.core_data_out_valid) begin
            rsp_data_q  <= bus.core_data_out;
            rsp_err_q   <= 1'b0;
            rsp_id_q    <= job_id_q;
            rsp_valid_q <= 1'b1;
            core_en_q   <= 1'b0;
            state_q     <= DONE;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_id_q    <= job_id_q;
            rsp_valid_q <= 1'b1;
            core_en_q   <= 1'b0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= GAP;
          end
        end
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready   = req_ready[0];
  assign bus.req1_ready   = req_ready[1];
  assign bus.core_en      = core_en_q;
  assign bus.core_data_in = core_data_in_q;
  assign bus.core_key_in  = core_key_in_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.busy         = (state_q != IDLE);
endmodule

// File: doc/aes_req_sched.md
Name: aes_req_sched

Overview:
- Two-requester scheduler in front of the single AES_top encryption core.
- Accepts plaintext/key jobs on two valid/ready ports and arbitrates between them round-robin.
- Holds the core's enable and operands stable for the whole encryption, then captures the result.
- Returns the result on one response channel tagged with the requester id; a watchdog aborts a hung core.

Parameters:
- DW, 128, plaintext/ciphertext width
- KW, 128, key width
- TIMEOUT_CYC, 64, max cycles in BUSY before abort; must be ≥ core latency plus margin
- CNT_W, 7, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYC

Ports:
- AES_clk  in  1  clock
- AES_rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 job valid
- req0_ready  out  1  requester 0 job accepted when valid&ready
- req0_data  in  DW  requester 0 plaintext
- req0_key  in  KW  requester 0 key
- req1_valid / req1_ready / req1_data / req1_key  as above, requester 1
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  requester index of the response
- rsp_data  out  DW  ciphertext; zero when rsp_err=1
- rsp_err  out  1  1 = watchdog timeout
- core_en  out  1  drives AES_en
- core_data_in  out  DW  drives AES_data_in
- core_key_in  out  KW  drives AES_key_in
- core_data_out  in  DW  from AES_data_out
- core_data_out_valid  in  1  from AES_data_out_valid
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async assert, synchronous deassert sampled on AES_clk):
  - State=IDLE.
  - All outputs 0: core_en, core_data_in, core_key_in, rsp_valid, rsp_id, rsp_data, rsp_err, req*_ready, busy.
  - Round-robin pointer rr=0 (requester 0 has priority first).
  - Watchdog counter=0.
- Reset mid-operation aborts the job immediately. core_en drops asynchronously; the in-flight job is lost with no response.
- FSM states: IDLE, LOAD, BUSY, DONE, GAP.
- IDLE:
  - req*_ready is combinational: asserted only for the granted requester, and only in IDLE.
  - One valid → grant it. Both valid → grant requester rr.
  - On handshake: register data/key into core_data_in/core_key_in, record the id, set rr to the non-granted index, go to LOAD.
  - No handshake → stay.
- LOAD (1 cycle): core_en=1, operands stable, counter cleared; go to BUSY.
- BUSY:
  - core_en=1; core_data_in/core_key_in held constant.
  - Counter increments each cycle.
  - core_data_out_valid=1 → capture core_data_out into rsp_data, rsp_err=0, go to DONE.
  - Else if counter==TIMEOUT_CYC-1 → rsp_data=0, rsp_err=1, go to DONE.
  - A valid arriving in the same cycle as the timeout wins.
- DONE:
  - core_en=0, rsp_valid=1; rsp_id/rsp_data/rsp_err stable until rsp_ready.
  - On rsp_valid&rsp_ready go to GAP.
  - core_data_out_valid pulses seen here are ignored.
- GAP (1 cycle):
  - core_en=0, rsp_valid=0; go to IDLE.
  - Guarantees core_en is low for at least 2 cycles between jobs so the core re-initialises.
- Throughput: minimum job period = core latency + 4 cycles (IDLE, LOAD, DONE, GAP) with rsp_ready held high.
- Latency:
  - Request handshake to core_en rise: 1 cycle.
  - core_data_out_valid to rsp_valid: 1 cycle.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1. A single active requester is served back-to-back with no idle penalty.
- Core inputs change only on the IDLE→LOAD edge; req*_data/key changes at any other time are invisible to the core.
- core_data_out_valid while IDLE or LOAD is ignored and does not generate a response.

Decomposition:
- Shared package aes_pkg:
  - state enum {IDLE, LOAD, BUSY, DONE, GAP}
  - constants AES_DW=128, AES_KW=128, AES_TIMEOUT_DEF=64
- One natural sub-module: aes_rr_arb2, a 2-way round-robin arbiter (inputs valid[1:0], en, update; output grant one-hot, internal rr pointer).
- Datapath registers and watchdog stay in aes_req_sched.

Test Plan:
1. Single job, normal completion:
   - Stimulus: req0 sends data=128'h00000053_00000000_00000000_00000000, key=128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc.
   - Response: core_en high continuously until core_data_out_valid; rsp_id=0, rsp_err=0, rsp_data equals the core output and the golden model.
2. Contention:
   - Stimulus: req0 and req1 valid in the same cycle, all held valid for 4 jobs.
   - Response: grant order 0,1,0,1 and rsp_id sequence 0,1,0,1.
3. Backpressure:
   - Stimulus: rsp_ready=0 for 10 cycles after rsp_valid.
   - Response: rsp fields stable, core_en=0, req*_ready=0 throughout; next job starts ≥2 cycles after the response handshake.
4. Timeout:
   - Stimulus: stub core never asserts valid, TIMEOUT_CYC=64.
   - Response: exactly 64 BUSY cycles; then rsp_valid=1, rsp_err=1, rsp_data=0, core_en falls.
5. Mid-operation reset:
   - Stimulus: assert AES_rst_n=0 during BUSY.
   - Response: core_en=0 immediately with no clock edge; all outputs 0; after release, a new req1 job completes normally with rsp_id=1.
6. Operand isolation and spurious valid:
   - Stimulus: change req0_data while BUSY; pulse core_data_out_valid during IDLE.
   - Response: core_data_in unchanged while BUSY; no rsp_valid generated by the IDLE pulse.
